// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: EX forwarding selects, load-use
// bubble insertion, taken-branch flushes and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [REG_AW-1:0] RD_M,
    input  logic [REG_AW-1:0] RD_W,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE,
    input  logic              PCSrcE,
    input  logic              cnt_clr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    generate
        if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 7) begin : g_bad_bubbles
            $error("pipeline_hazard_ctrl: LOAD_BUBBLES must be in 1..7");
        end
    endgenerate

    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       STALL    = 1'b1;
    localparam logic [2:0]       BUB_INIT = 3'(LOAD_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [0:0] state, state_nxt;
    logic [2:0] bub_cnt, bub_nxt;
    logic       lw_hit;
    logic       stall_raw, flush_d_raw, flush_e_raw;
    logic [1:0] fwd_a, fwd_b;

    // M-stage result is younger than W, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        if (we_m && rd_m != '0 && rd_m == rs)
            return 2'b10;
        else if (we_w && rd_w != '0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a  = fwd_sel(Rs1_E, RD_M, RegWriteM, RD_W, RegWriteW);
    assign fwd_b  = fwd_sel(Rs2_E, RD_M, RegWriteM, RD_W, RegWriteW);
    assign lw_hit = ResultSrcE && RegWriteE && RD_E != '0 &&
                    (RD_E == Rs1_D || RD_E == Rs2_D);

    always_comb begin
        state_nxt   = state;
        bub_nxt     = bub_cnt;
        stall_raw   = 1'b0;
        flush_d_raw = 1'b0;
        flush_e_raw = 1'b0;
        if (PCSrcE) begin
            // The stalled decode instruction is on the wrong path; drop it.
            flush_d_raw = 1'b1;
            flush_e_raw = 1'b1;
            state_nxt   = IDLE;
            bub_nxt     = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (lw_hit) begin
                        stall_raw   = 1'b1;
                        flush_e_raw = 1'b1;
                        if (LOAD_BUBBLES > 1) begin
                            state_nxt = STALL;
                            bub_nxt   = BUB_INIT;
                        end
                    end
                end
                STALL: begin
                    stall_raw   = 1'b1;
                    flush_e_raw = 1'b1;
                    bub_nxt     = bub_cnt - 3'd1;
                    if (bub_cnt == 3'd1)
                        state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    bub_nxt   = 3'd0;
                end
            endcase
        end
    end

    // Reset overrides every output without waiting for a clock edge.
    assign ForwardAE = rst ? 2'b00 : fwd_a;
    assign ForwardBE = rst ? 2'b00 : fwd_b;
    assign StallF    = !rst && stall_raw;
    assign StallD    = !rst && stall_raw;
    assign FlushD    = !rst && flush_d_raw;
    assign FlushE    = !rst && flush_e_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bub_cnt <= 3'd0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (cnt_clr)
                stall_cnt <= '0;
            else if (StallD && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (cnt_clr)
                flush_cnt <= '0;
            else if (PCSrcE && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (1 bubble / 32-bit
// counters, 3 bubbles / 4-bit counters) checked against a remaining-bubble model.
module tb_pipeline_hazard_ctrl;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic we_e, we_m, we_w, ld_e, pc_e, cnt_clr;

    logic [1:0]  fa1, fb1, fa3, fb3;
    logic        sf1, sd1, fd1, fe1, sf3, sd3, fd3, fe3;
    logic [31:0] sc1, fc1;
    logic [3:0]  sc3, fc3;

    pipeline_hazard_ctrl #(.REG_AW(AW), .LOAD_BUBBLES(1), .CNT_W(32)) u_lb1 (
        .clk(clk), .rst(rst), .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Rs1_E(rs1_e), .Rs2_E(rs2_e),
        .RD_E(rd_e), .RD_M(rd_m), .RD_W(rd_w), .RegWriteE(we_e), .RegWriteM(we_m),
        .RegWriteW(we_w), .ResultSrcE(ld_e), .PCSrcE(pc_e), .cnt_clr(cnt_clr),
        .ForwardAE(fa1), .ForwardBE(fb1), .StallF(sf1), .StallD(sd1), .FlushD(fd1),
        .FlushE(fe1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    pipeline_hazard_ctrl #(.REG_AW(AW), .LOAD_BUBBLES(3), .CNT_W(4)) u_lb3 (
        .clk(clk), .rst(rst), .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Rs1_E(rs1_e), .Rs2_E(rs2_e),
        .RD_E(rd_e), .RD_M(rd_m), .RD_W(rd_w), .RegWriteE(we_e), .RegWriteM(we_m),
        .RegWriteW(we_w), .ResultSrcE(ld_e), .PCSrcE(pc_e), .cnt_clr(cnt_clr),
        .ForwardAE(fa3), .ForwardBE(fb3), .StallF(sf3), .StallD(sd3), .FlushD(fd3),
        .FlushE(fe3), .stall_cnt(sc3), .flush_cnt(fc3)
    );

    typedef struct {
        logic [1:0]  fa, fb;
        logic [3:0]  o1, o3;     // {StallF, StallD, FlushD, FlushE}
        logic [31:0] sc1, fc1;
        logic [3:0]  sc3, fc3;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Model state: bubbles still owed after this cycle, plus counters.
    int          rem1 = 0, rem3 = 0;
    logic [31:0] m_sc1 = '0, m_fc1 = '0;
    logic [3:0]  m_sc3 = '0, m_fc3 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
        if (we_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (we_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_lw();
        return ld_e && we_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    endfunction

    function automatic logic [3:0] m_out(input int rem);
        logic st;
        st = !rst && !pc_e && (rem > 0 || m_lw());
        return {st, st, !rst && pc_e, !rst && (pc_e || st)};
    endfunction

    task automatic idle_in();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        we_e = 0; we_m = 0; we_w = 0; ld_e = 0; pc_e = 0; cnt_clr = 0;
    endtask

    task automatic load_hazard();
        idle_in();
        ld_e = 1; we_e = 1; rd_e = 3; rs2_d = 3; rs1_d = 9;
    endtask

    function automatic int next_rem(input int rem, input int lb);
        if (rst || pc_e) return 0;
        if (rem > 0) return rem - 1;
        if (m_lw()) return lb - 1;
        return 0;
    endfunction

    // One cycle: predict, compare, then advance the model across the edge.
    task automatic cycle();
        exp_t e, g;
        logic [3:0] o1, o3;
        #1;
        o1 = m_out(rem1);
        o3 = m_out(rem3);
        if (rst) begin
            m_sc1 = '0; m_fc1 = '0; m_sc3 = '0; m_fc3 = '0;
        end
        e.fa  = rst ? 2'b00 : m_fwd(rs1_e);
        e.fb  = rst ? 2'b00 : m_fwd(rs2_e);
        e.o1  = o1;       e.o3  = o3;
        e.sc1 = m_sc1;    e.fc1 = m_fc1;
        e.sc3 = m_sc3;    e.fc3 = m_fc3;
        exp_q.push_back(e);

        g = exp_q.pop_front();
        chk("fwdA_lb1", 32'(fa1), 32'(g.fa));
        chk("fwdB_lb1", 32'(fb1), 32'(g.fb));
        chk("fwdA_lb3", 32'(fa3), 32'(g.fa));
        chk("fwdB_lb3", 32'(fb3), 32'(g.fb));
        chk("ctl_lb1", 32'({sf1, sd1, fd1, fe1}), 32'(g.o1));
        chk("ctl_lb3", 32'({sf3, sd3, fd3, fe3}), 32'(g.o3));
        chk("stall_cnt_lb1", sc1, g.sc1);
        chk("flush_cnt_lb1", fc1, g.fc1);
        chk("stall_cnt_lb3", 32'(sc3), 32'(g.sc3));
        chk("flush_cnt_lb3", 32'(fc3), 32'(g.fc3));

        @(posedge clk);
        if (!rst) begin
            if (cnt_clr) begin
                m_sc1 = '0; m_fc1 = '0; m_sc3 = '0; m_fc3 = '0;
            end else begin
                if (o1[2] && m_sc1 != 32'hFFFF_FFFF) m_sc1++;
                if (pc_e && m_fc1 != 32'hFFFF_FFFF) m_fc1++;
                if (o3[2] && m_sc3 != 4'hF) m_sc3++;
                if (pc_e && m_fc3 != 4'hF) m_fc3++;
            end
        end
        rem1 = next_rem(rem1, 1);
        rem3 = next_rem(rem3, 3);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        idle_in();
        // Forwarding candidates present during reset must still read 00.
        rs1_e = 5; rd_m = 5; we_m = 1;
        rst = 1;
        cycle(); cycle();
        rst = 0;

        idle_in();
        rs1_e = 5; rs2_e = 5; rd_m = 5; we_m = 1; rd_w = 5; we_w = 1;
        cycle();
        we_m = 0;
        cycle();
        rd_m = 0; rd_w = 0; we_m = 1;
        cycle();
        rs2_e = 7; rd_w = 7; rd_m = 5;
        cycle();

        // Single load-use hazard, then the load leaves E.
        idle_in(); cnt_clr = 1; cycle();
        load_hazard(); cycle();
        idle_in(); repeat (4) cycle();

        // Load to x0 never stalls.
        idle_in(); ld_e = 1; we_e = 1; rd_e = 0; rs1_d = 0; cycle();

        // Branch taken on the second stall cycle.
        idle_in(); cnt_clr = 1; cycle();
        load_hazard(); cycle();
        idle_in(); pc_e = 1; cycle();
        idle_in(); repeat (3) cycle();

        // Load-use and branch in the same cycle.
        load_hazard(); pc_e = 1; cycle();
        idle_in(); repeat (3) cycle();

        // Flush counter saturation on the 4-bit instance, then clear wins.
        idle_in(); cnt_clr = 1; cycle();
        idle_in(); pc_e = 1; repeat (20) cycle();
        cnt_clr = 1; cycle();
        idle_in(); repeat (2) cycle();

        // Reset in the middle of a multi-bubble stall.
        load_hazard(); cycle();
        idle_in(); rst = 1; cycle();
        rst = 0; repeat (4) cycle();

        // Mixed random traffic over a small register range to force hits.
        repeat (200) begin
            rs1_d = AW'($urandom_range(0, 3)); rs2_d = AW'($urandom_range(0, 3));
            rs1_e = AW'($urandom_range(0, 3)); rs2_e = AW'($urandom_range(0, 3));
            rd_e  = AW'($urandom_range(0, 3)); rd_m  = AW'($urandom_range(0, 3));
            rd_w  = AW'($urandom_range(0, 3));
            we_e = 1'($urandom_range(0, 1)); we_m = 1'($urandom_range(0, 1));
            we_w = 1'($urandom_range(0, 1)); ld_e = 1'($urandom_range(0, 1));
            pc_e    = ($urandom_range(0, 7) == 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
